mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the RV32I datapath. Decodes `op`/`funct3`/`funct7` from the instruction register and sequences fetch, decode, execute, memory and writeback. It drives every mux select and write enable of the datapath, plus the external memory write strobe. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-low reset.
- `op` in 7: instruction opcode, instr[6:0].
- `funct3` in 3: instr[14:12].
- `funct7` in 1: instr[30].
- `zero_flag` in 1: ALU result == 0.
- `comp_flag` in 1: ALU result bit 0 (SLT/SLTU outcome).
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1: write enables.
- `AddrSrc` out 1: memory address select, 0 = PC, 1 = result.
- `WDSrc` out 1: regfile write-data select, 0 = result, 1 = PC (link).
- `SrcA` out 2: ALU A select, 00 = PC, 01 = old PC, 10 = rs1 reg, 11 = zero.
- `SrcB` out 2: ALU B select, 00 = rs2 reg, 01 = imm, 10 = const 4.
- `ResSrc` out 2: result select, 00 = registered ALU, 01 = extended mem data, 1x = ALU direct.
- `DataSrc` out 2: load extension, 00 = raw, 01 = lb, 10 = lh.
- `ImmSrc` out 3: immediate type, 0 = I, 1 = S, 2 = B, 3 = J, 4 = U.
- `ALUControll` out 4: ALU operation code (package constants).
- `mem_size` out 2: funct3[1:0] during MEMWRITE, else 00.
- `illegal` out 1: sticky unsupported-instruction flag.
- `instret` out CNT_W: retired instruction count.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- Outputs are a Moore decode of the state. Two exceptions are combinational on inputs: ALUControll/ImmSrc are also functions of op/funct, and PCWrite in BRANCH is the branch condition.
- Unlisted outputs are 0.
- FETCH: AddrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ADD, ResSrc=1x, PCWrite=1 → DECODE.
- DECODE: SrcA=01, SrcB=01, ADD. ImmSrc=J if op=JAL, else B. This precomputes the jump/branch target into the ALU register.
- DECODE next state by op:
  - 0000011 → MEMADR; 0100011 → MEMADR
  - 0110011 → EXEC_R; 0010011 → EXEC_I
  - 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR
  - 0110111 → LUI; 0010111 → AUIPC
  - anything else → TRAP
- MEMADR: SrcA=10, SrcB=01, ADD, ImmSrc=I (load) or S (store) → MEMREAD (load) or MEMWRITE (store).
- MEMREAD: AddrSrc=1, ResSrc=00 → MEMWB.
- MEMWB: ResSrc=01, RegWrite=1, DataSrc from funct3: 000 → 01, 001 → 10, else 00 → FETCH.
- MEMWRITE: AddrSrc=1, ResSrc=00, MemWrite=1 → FETCH.
- EXEC_R: SrcA=10, SrcB=00. EXEC_I: SrcA=10, SrcB=01, ImmSrc=I. Both → ALUWB.
- ALUWB: ResSrc=00, RegWrite=1 → FETCH.
- ALU decode:
  - funct3 000 → ADD; for R-type with funct7=1 → SUB.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR.
  - 101 → SRA if funct7=1, else SRL.
  - 110 → OR, 111 → AND.
  - I-type 000 is always ADD.
- BRANCH: SrcA=10, SrcB=00, ResSrc=00 → FETCH. ALU op and PCWrite condition by funct3:
  - beq: SUB, zero_flag=1; bne: SUB, zero_flag=0.
  - blt: SLT, comp_flag=1; bge: SLT, comp_flag=0.
  - bltu: SLTU, comp_flag=1; bgeu: SLTU, comp_flag=0.
  - funct3 010/011 → TRAP.
- JAL: ResSrc=00, PCWrite=1, RegWrite=1, WDSrc=1 → FETCH.
- JALR: SrcA=10, SrcB=01, ImmSrc=I, ADD, ResSrc=1x, PCWrite=1, RegWrite=1, WDSrc=1 → FETCH. The controller does not clear target bit 0.
- LUI: SrcA=11, SrcB=01, ImmSrc=U, ADD, ResSrc=1x, RegWrite=1 → FETCH.
- AUIPC: same as LUI but SrcA=01.
- TRAP: all enables 0, `illegal`=1, state held until reset.
- instret increments by 1 on every transition into FETCH from a non-TRAP, non-reset state. It wraps modulo 2^CNT_W.

## Timing
- Reset (rst=0 at posedge):
  - next state FETCH, instret=0, illegal=0.
  - While rst=0, PCWrite, IRWrite, RegWrite and MemWrite are forced 0 combinationally.
- Reset mid-instruction abandons the instruction with no partial write.
- Memory read is combinational, so FETCH captures the instruction in the same cycle.
- Cycles per instruction:
  - load 5; R/I-ALU 4; store 4.
  - branch, jal, jalr, lui, auipc 3.
- Illegal instruction: TRAP is entered in the cycle after DECODE, or after BRANCH for bad funct3. `illegal` is asserted from that cycle onward.

## Structure
- Package `rv_ctrl_pkg`:
  - state enum;
  - opcode constants;
  - ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001;
  - SrcA/SrcB/ResSrc/ImmSrc/DataSrc encodings.
- Sub-module `alu_decoder`: combinational mapping of (state class, funct3, funct7) to ALUControll.

## Test plan
- Reset held 3 cycles, then released: state FETCH with IRWrite=1, PCWrite=1; instret=0; no enables during reset.
- add x3,x1,x2 (funct7=0), then sub: 4 cycles each; ALUWB has RegWrite=1, ResSrc=00; ALUControll 0000 then 0001; instret=2.
- lb (funct3=000): FETCH→DECODE→MEMADR→MEMREAD→MEMWB. MEMREAD has AddrSrc=1; MEMWB has DataSrc=01, RegWrite=1. sw: MemWrite=1 for exactly 1 cycle with mem_size=10.
- bne with zero_flag=1 → PCWrite=0. blt with comp_flag=1 → PCWrite=1, ALUControll=1000. bgeu with comp_flag=0 → PCWrite=1, ALUControll=1001.
- jal: DECODE ImmSrc=3; JAL state has PCWrite=1, RegWrite=1, WDSrc=1; 3 cycles total.
- op=0000000 → TRAP, illegal=1, all enables 0 for 10+ cycles, instret frozen. rst=0 clears both.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// The datapath decodes the same select encodings, so change them in both places.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    // Selects which decode rule the ALU decoder applies
    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_R   = 2'd1,
        CLS_I   = 2'd2,
        CLS_BR  = 2'd3
    } alu_cls_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] DS_RAW = 2'b00;
    localparam logic [1:0] DS_LB  = 2'b01;
    localparam logic [1:0] DS_LH  = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the current decode class and funct fields to an ALU operation code.
// Purely combinational; the FSM chooses the class per state.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_cls_e   cls,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        unique case (cls)
            CLS_R, CLS_I: begin
                case (funct3)
                    3'b000: alu_op = (cls == CLS_R && funct7) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = funct7 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CLS_BR: begin
                // beq/bne compare by subtraction, signed/unsigned pairs by set-less-than
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: Moore decode of state for the datapath selects,
// plus retired-instruction counter and sticky illegal-instruction flag.
module mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7,
    input  logic             zero_flag,
    input  logic             comp_flag,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             AddrSrc,
    output logic             WDSrc,
    output logic [1:0]       SrcA,
    output logic [1:0]       SrcB,
    output logic [1:0]       ResSrc,
    output logic [1:0]       DataSrc,
    output logic [2:0]       ImmSrc,
    output logic [3:0]       ALUControll,
    output logic [1:0]       mem_size,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e   state, next_state;
    alu_cls_e alu_cls;
    logic     br_taken;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        case (funct3)
            3'b000:  br_taken = zero_flag;
            3'b001:  br_taken = !zero_flag;
            3'b100:  br_taken = comp_flag;
            3'b101:  br_taken = !comp_flag;
            3'b110:  br_taken = comp_flag;
            3'b111:  br_taken = !comp_flag;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AddrSrc    = 1'b0;
        WDSrc      = 1'b0;
        SrcA       = SRCA_PC;
        SrcB       = SRCB_RS2;
        ResSrc     = RES_ALUREG;
        DataSrc    = DS_RAW;
        ImmSrc     = IMM_I;
        mem_size   = 2'b00;
        alu_cls    = CLS_ADD;

        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                SrcB       = SRCB_FOUR;
                ResSrc     = RES_ALU;
                PCWrite    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target is precomputed here from the old PC
                SrcA   = SRCA_OLDPC;
                SrcB   = SRCB_IMM;
                ImmSrc = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXEC_R;
                    OP_I:              next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                SrcA       = SRCA_RS1;
                SrcB       = SRCB_IMM;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AddrSrc    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ResSrc   = RES_MEM;
                RegWrite = 1'b1;
                case (funct3)
                    3'b000:  DataSrc = DS_LB;
                    3'b001:  DataSrc = DS_LH;
                    default: DataSrc = DS_RAW;
                endcase
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AddrSrc    = 1'b1;
                MemWrite   = 1'b1;
                mem_size   = funct3[1:0];
                next_state = S_FETCH;
            end
            S_EXEC_R: begin
                SrcA       = SRCA_RS1;
                alu_cls    = CLS_R;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                SrcA       = SRCA_RS1;
                SrcB       = SRCB_IMM;
                alu_cls    = CLS_I;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                SrcA       = SRCA_RS1;
                alu_cls    = CLS_BR;
                PCWrite    = br_taken;
                next_state = (funct3[2:1] == 2'b01) ? S_TRAP : S_FETCH;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                WDSrc      = 1'b1;
                next_state = S_FETCH;
            end
            S_JALR: begin
                SrcA       = SRCA_RS1;
                SrcB       = SRCB_IMM;
                ResSrc     = RES_ALU;
                PCWrite    = 1'b1;
                RegWrite   = 1'b1;
                WDSrc      = 1'b1;
                next_state = S_FETCH;
            end
            S_LUI, S_AUIPC: begin
                SrcA       = (state == S_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                SrcB       = SRCB_IMM;
                ImmSrc     = IMM_U;
                ResSrc     = RES_ALU;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_TRAP;
        endcase

        // No architectural write may escape while reset is held
        if (!rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end

    alu_decoder u_alu_decoder (
        .cls    (alu_cls),
        .funct3 (funct3),
        .funct7 (funct7),
        .alu_op (ALUControll)
    );

    // TRAP never returns to FETCH, so counting every FETCH entry is exact
    always_ff @(posedge clk) begin
        if (!rst) begin
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            if (next_state == S_FETCH)
                instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            if (next_state == S_TRAP)
                illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks one instruction of each class through
// the FSM and checks the decoded controls cycle by cycle.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        zero_flag;
    logic        comp_flag;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AddrSrc, WDSrc;
    logic [1:0]  SrcA, SrcB, ResSrc, DataSrc, mem_size;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControll;
    logic        illegal;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .comp_flag(comp_flag),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AddrSrc(AddrSrc), .WDSrc(WDSrc), .SrcA(SrcA), .SrcB(SrcB), .ResSrc(ResSrc),
        .DataSrc(DataSrc), .ImmSrc(ImmSrc), .ALUControll(ALUControll),
        .mem_size(mem_size), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs the four write enables as {PC,IR,Reg,Mem}
    function automatic logic [3:0] en();
        return {PCWrite, IRWrite, RegWrite, MemWrite};
    endfunction

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7 = f7;
    endtask

    initial begin
        rst = 1'b0; zero_flag = 1'b0; comp_flag = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_en", {28'd0, en()}, 32'h0);
        end
        chk("rst_instret", instret, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        rst = 1'b1;
        #1;
        chk("fetch_en", {28'd0, en()}, 32'b1100);
        chk("fetch_srcb", {30'd0, SrcB}, 32'd2);

        // add x3,x1,x2
        tick(); chk("add_dec_srca", {30'd0, SrcA}, 32'd1);
        chk("add_dec_imm", {29'd0, ImmSrc}, 32'd2);
        tick(); chk("add_exec_alu", {28'd0, ALUControll}, 32'h0);
        chk("add_exec_srcb", {30'd0, SrcB}, 32'd0);
        tick(); chk("add_wb_en", {28'd0, en()}, 32'b0010);
        chk("add_wb_res", {30'd0, ResSrc}, 32'd0);
        tick(); chk("add_fetch_en", {28'd0, en()}, 32'b1100);
        chk("add_instret", instret, 32'd1);

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1);
        tick(); tick(); chk("sub_exec_alu", {28'd0, ALUControll}, 32'h1);
        tick(); chk("sub_wb_en", {28'd0, en()}, 32'b0010);
        tick(); chk("sub_instret", instret, 32'd2);

        // lb
        set_instr(7'b0000011, 3'b000, 1'b0);
        tick(); tick(); chk("lb_madr_imm", {29'd0, ImmSrc}, 32'd0);
        chk("lb_madr_srca", {30'd0, SrcA}, 32'd2);
        tick(); chk("lb_mrd_addr", {31'd0, AddrSrc}, 32'd1);
        chk("lb_mrd_en", {28'd0, en()}, 32'd0);
        tick(); chk("lb_mwb_ds", {30'd0, DataSrc}, 32'd1);
        chk("lb_mwb_en", {28'd0, en()}, 32'b0010);
        chk("lb_mwb_res", {30'd0, ResSrc}, 32'd1);
        tick(); chk("lb_fetch_en", {28'd0, en()}, 32'b1100);
        chk("lb_instret", instret, 32'd3);

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); tick(); chk("sw_madr_imm", {29'd0, ImmSrc}, 32'd1);
        tick(); chk("sw_mwr_en", {28'd0, en()}, 32'b0001);
        chk("sw_mwr_size", {30'd0, mem_size}, 32'd2);
        chk("sw_mwr_addr", {31'd0, AddrSrc}, 32'd1);
        tick(); chk("sw_fetch_en", {28'd0, en()}, 32'b1100);
        chk("sw_fetch_size", {30'd0, mem_size}, 32'd0);
        chk("sw_instret", instret, 32'd4);

        // bne not taken
        set_instr(7'b1100011, 3'b001, 1'b0); zero_flag = 1'b1;
        tick(); tick(); chk("bne_pcw", {31'd0, PCWrite}, 32'd0);
        chk("bne_alu", {28'd0, ALUControll}, 32'h1);
        tick(); chk("bne_instret", instret, 32'd5);

        // blt taken
        set_instr(7'b1100011, 3'b100, 1'b0); zero_flag = 1'b0; comp_flag = 1'b1;
        tick(); tick(); chk("blt_pcw", {31'd0, PCWrite}, 32'd1);
        chk("blt_alu", {28'd0, ALUControll}, 32'h8);
        tick(); chk("blt_instret", instret, 32'd6);

        // bgeu taken
        set_instr(7'b1100011, 3'b111, 1'b0); comp_flag = 1'b0;
        tick(); tick(); chk("bgeu_pcw", {31'd0, PCWrite}, 32'd1);
        chk("bgeu_alu", {28'd0, ALUControll}, 32'h9);
        tick(); chk("bgeu_instret", instret, 32'd7);

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0);
        tick(); chk("jal_dec_imm", {29'd0, ImmSrc}, 32'd3);
        tick(); chk("jal_en", {28'd0, en()}, 32'b1010);
        chk("jal_wdsrc", {31'd0, WDSrc}, 32'd1);
        tick(); chk("jal_fetch_en", {28'd0, en()}, 32'b1100);
        chk("jal_instret", instret, 32'd8);

        // lui
        set_instr(7'b0110111, 3'b000, 1'b0);
        tick(); tick(); chk("lui_srca", {30'd0, SrcA}, 32'd3);
        chk("lui_imm", {29'd0, ImmSrc}, 32'd4);
        chk("lui_en", {28'd0, en()}, 32'b0010);
        tick(); chk("lui_instret", instret, 32'd9);

        // illegal opcode
        set_instr(7'b0000000, 3'b000, 1'b0);
        tick(); chk("trap_dec_illegal", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("trap_en", {28'd0, en()}, 32'd0);
            chk("trap_illegal", {31'd0, illegal}, 32'd1);
            chk("trap_instret", instret, 32'd9);
        end
        rst = 1'b0;
        tick(); chk("clr_illegal", {31'd0, illegal}, 32'd0);
        chk("clr_instret", instret, 32'd0);
        chk("clr_en", {28'd0, en()}, 32'd0);
        rst = 1'b1;
        #1;
        chk("clr_fetch_en", {28'd0, en()}, 32'b1100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
